// File: rtl/dac_cfg_pkg.sv
// Shared types for the DAC configuration sequencer.
package dac_cfg_pkg;

   localparam int DAC_WORD_W = 72;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_GAP
   } state_e;

   typedef enum logic {
      SRC_TABLE,
      SRC_HOST
   } src_e;

endpackage

// File: rtl/dac_cfg_timer.sv
// Loadable down-counter with terminal-count flag, shared by the inter-word gap
// and the per-transfer timeout. Load wins over counting; the count holds at zero.
module dac_cfg_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc
);

   logic [W-1:0] count_q, count_d;

   // next count: reload, or step down toward zero while enabled
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == '0);

endmodule

// File: rtl/dac_cfg_sequencer.sv
// DAC configuration sequencer: walks the init ROM through the shared SPI engine
// and serves single host writes in between. Build macro DAC_CFG_RETRY_EN gives
// each word one re-issue after a timeout before cfg_err is raised.
//
// state | meaning
// IDLE  | waiting for cfg_start or a host write
// FETCH | rom_addr presents the current word index
// LOAD  | ROM word captured into spi_data_out
// ISSUE | one-cycle spi_start, timeout timer armed
// WAIT  | transfer in flight under timeout supervision
// GAP   | post-transfer idle, then next word or back to IDLE
module dac_cfg_sequencer
   import dac_cfg_pkg::*;
#(
   parameter int NUM_WORDS      = 16,
   parameter int WORD_W         = DAC_WORD_W,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic              clk_20mhz_in,
   input  logic              rst_n_in,
   input  logic              cfg_start,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [AW-1:0]     rom_addr,
   input  logic [WORD_W-1:0] rom_data,
   input  logic              host_wr_req,
   input  logic [WORD_W-1:0] host_wr_data,
   output logic              host_wr_ack,
   output logic              spi_start,
   output logic [WORD_W-1:0] spi_data_out,
   input  logic              spi_end
);

   localparam int TW_TMO = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TW_GAP = $clog2(GAP_CYCLES + 1);
   localparam int TW     = (TW_TMO > TW_GAP) ? TW_TMO : TW_GAP;
   // Timer loaded in ISSUE hits zero in the WAIT cycle TIMEOUT_CYCLES-1 clocks
   // after spi_start, so cfg_err shows exactly TIMEOUT_CYCLES clocks after it.
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 2);
   // Timer loaded on spi_end: busy drops (or FETCH starts) GAP_CYCLES after spi_end.
   localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

   state_e            state_q, state_d;
   src_e              src_q, src_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              tmr_load, tmr_tc, tmr_en;
   logic [TW-1:0]     tmr_val;
   logic              retry_q;

   dac_cfg_timer #(.W(TW)) u_timer (
      .clk      (clk_20mhz_in),
      .rst_n    (rst_n_in),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .tc       (tmr_tc)
   );

   assign tmr_en = (state_q == S_WAIT) || (state_q == S_GAP);

`ifdef DAC_CFG_RETRY_EN
   logic retry_d;

   // one re-issue per word; the flag clears whenever a new word is taken
   always_comb begin
      retry_d = retry_q;
      if ((state_q == S_FETCH) || host_wr_ack) begin
         retry_d = 1'b0;
      end else if ((state_q == S_WAIT) && !spi_end && tmr_tc) begin
         retry_d = 1'b1;
      end
   end

   // retry flag register
   always_ff @(posedge clk_20mhz_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         retry_q <= 1'b0;
      end else begin
         retry_q <= retry_d;
      end
   end
`else
   // without retry every word behaves as if its retry were already spent
   assign retry_q = 1'b1;
`endif

   // next-state and Mealy outputs
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      idx_d       = idx_q;
      data_d      = data_q;
      err_d       = err_q;
      done_d      = 1'b0;
      host_wr_ack = 1'b0;
      spi_start   = 1'b0;
      tmr_load    = 1'b0;
      tmr_val     = TMO_LOAD;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               err_d   = 1'b0;
               idx_d   = '0;
               src_d   = SRC_TABLE;
               state_d = S_FETCH;
            end else if (host_wr_req) begin
               data_d      = host_wr_data;
               host_wr_ack = 1'b1;
               src_d       = SRC_HOST;
               state_d     = S_ISSUE;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            data_d  = rom_data;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            spi_start = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TMO_LOAD;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (spi_end) begin
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
               state_d  = S_GAP;
            end else if (tmr_tc) begin
               if (!retry_q) begin
                  state_d = S_ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (tmr_tc) begin
               if (src_q == SRC_HOST) begin
                  state_d = S_IDLE;
               end else if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // sequencer state registers
   always_ff @(posedge clk_20mhz_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         src_q   <= SRC_TABLE;
         idx_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign cfg_busy     = (state_q != S_IDLE);
   assign cfg_done     = done_q;
   assign cfg_err      = err_q;
   assign rom_addr     = idx_q;
   assign spi_data_out = data_q;

endmodule
